// File: rtl/painterengine_gpu_scanout_fetcher.sv
// Frame scanout fetch controller: walks a framebuffer line by line and issues
// DMA reader bursts whenever the pixel FIFO has room for the whole burst.
module painterengine_gpu_scanout_fetcher #(
    parameter int BLOCK_WORDS      = 32,
    parameter int FIFO_COUNT_WIDTH = 8
) (
    input  logic                        i_wire_clock,
    input  logic                        i_wire_reset,
    input  logic                        i_wire_enable,
    input  logic                        i_wire_continuous,
    input  logic                        i_wire_frame_start,
    input  logic [31:0]                 i_wire_image_address,
    input  logic [31:0]                 i_wire_image_stride,
    input  logic [15:0]                 i_wire_clip_width,
    input  logic [15:0]                 i_wire_clip_height,
    input  logic [1:0]                  i_wire_pixel_size_log2,
    input  logic [FIFO_COUNT_WIDTH-1:0] i_wire_fifo_free_count,
    output logic [31:0]                 o_wire_reader_address,
    output logic [31:0]                 o_wire_reader_length,
    output logic                        o_wire_reader_resetn,
    input  logic                        i_wire_reader_done,
    input  logic                        i_wire_reader_error,
    output logic                        o_wire_busy,
    output logic                        o_wire_frame_done,
    output logic [31:0]                 o_wire_state
);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_FRAME = 3'd1;
    localparam logic [2:0] S_CALC       = 3'd2;
    localparam logic [2:0] S_WAIT_SPACE = 3'd3;
    localparam logic [2:0] S_STREAMING  = 3'd4;
    localparam logic [2:0] S_CHECK      = 3'd5;
    localparam logic [2:0] S_DONE       = 3'd6;
    localparam logic [2:0] S_ERROR      = 3'd7;

    localparam logic [17:0] BLOCK_LEN = 18'(BLOCK_WORDS);

    logic [2:0]  r_state;
    logic        r_error_flag;
    logic [15:0] r_line;
    logic [15:0] r_width;
    logic [15:0] r_height;
    logic [1:0]  r_size_log2;
    logic [31:0] r_line_base;
    logic [31:0] r_stride;
    logic [17:0] r_word_x;
    logic [31:0] r_address;
    logic [31:0] r_length;
    logic        r_resetn;
    logic        r_frame_done;

    logic [17:0] w_line_bytes;
    logic [17:0] w_line_words;
    logic [17:0] w_remaining;
    logic [17:0] w_burst_len;
    logic [17:0] w_word_x_next;
    logic [15:0] w_line_next;
    logic [32:0] w_free_ext;
    logic        w_space_ok;

    // Line length in words is derived from latched config each cycle; shifts only.
    assign w_line_bytes  = {2'b00, r_width} << r_size_log2;
    assign w_line_words  = (w_line_bytes + 18'd3) >> 2;
    assign w_remaining   = w_line_words - r_word_x;
    assign w_burst_len   = (w_remaining > BLOCK_LEN) ? BLOCK_LEN : w_remaining;
    assign w_word_x_next = r_word_x + r_length[17:0];
    assign w_line_next   = r_line + 16'd1;
    assign w_free_ext    = 33'(i_wire_fifo_free_count);
    assign w_space_ok    = w_free_ext >= {1'b0, r_length};

    always_ff @(posedge i_wire_clock or posedge i_wire_reset) begin
        if (i_wire_reset) begin
            r_state      <= S_IDLE;
            r_error_flag <= 1'b0;
            r_line       <= 16'd0;
            r_width      <= 16'd0;
            r_height     <= 16'd0;
            r_size_log2  <= 2'd0;
            r_line_base  <= 32'd0;
            r_stride     <= 32'd0;
            r_word_x     <= 18'd0;
            r_address    <= 32'd0;
            r_length     <= 32'd0;
            r_resetn     <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (!i_wire_enable) begin
                // Abandons any in-flight burst and clears a sticky error.
                r_state      <= S_IDLE;
                r_resetn     <= 1'b0;
                r_error_flag <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_WAIT_FRAME;
                    S_WAIT_FRAME: begin
                        if (i_wire_frame_start) begin
                            r_line_base <= i_wire_image_address;
                            r_stride    <= i_wire_image_stride;
                            r_width     <= i_wire_clip_width;
                            r_height    <= i_wire_clip_height;
                            r_size_log2 <= (i_wire_pixel_size_log2 == 2'd3) ? 2'd2
                                                                            : i_wire_pixel_size_log2;
                            r_line      <= 16'd0;
                            r_word_x    <= 18'd0;
                            if (i_wire_clip_width == 16'd0 || i_wire_clip_height == 16'd0) begin
                                r_state      <= S_DONE;
                                r_frame_done <= 1'b1;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                    S_CALC: begin
                        r_address <= r_line_base + {12'd0, r_word_x, 2'b00};
                        r_length  <= {14'd0, w_burst_len};
                        r_state   <= S_WAIT_SPACE;
                    end
                    S_WAIT_SPACE: begin
                        if (w_space_ok) begin
                            r_resetn <= 1'b1;
                            r_state  <= S_STREAMING;
                        end
                    end
                    S_STREAMING: begin
                        if (i_wire_reader_error) begin
                            r_resetn     <= 1'b0;
                            r_error_flag <= 1'b1;
                            r_state      <= S_ERROR;
                        end else if (i_wire_reader_done) begin
                            r_resetn <= 1'b0;
                            r_word_x <= w_word_x_next;
                            r_state  <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        if (r_word_x < w_line_words) begin
                            r_state <= S_CALC;
                        end else begin
                            r_line      <= w_line_next;
                            r_line_base <= r_line_base + r_stride;
                            r_word_x    <= 18'd0;
                            if (w_line_next == r_height) begin
                                r_frame_done <= 1'b1;
                                r_state      <= S_DONE;
                            end else begin
                                r_state <= S_CALC;
                            end
                        end
                    end
                    S_DONE: begin
                        if (i_wire_continuous)
                            r_state <= S_WAIT_FRAME;
                    end
                    S_ERROR: r_resetn <= 1'b0;
                endcase
            end
        end
    end

    assign o_wire_reader_address = r_address;
    assign o_wire_reader_length  = r_length;
    assign o_wire_reader_resetn  = r_resetn;
    assign o_wire_frame_done     = r_frame_done;
    assign o_wire_busy           = (r_state == S_CALC) || (r_state == S_WAIT_SPACE) ||
                                   (r_state == S_STREAMING) || (r_state == S_CHECK);
    assign o_wire_state          = {12'd0, r_line, r_error_flag, r_state};

endmodule

// File: tb/tb_painterengine_gpu_scanout_fetcher.sv
// Bench for the scanout fetcher: directed and randomized frames checked against
// a burst-list model computed from frame geometry with plain arithmetic.
module tb_painterengine_gpu_scanout_fetcher;

    localparam int BW = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        continuous = 1'b0;
    logic        frame_start = 1'b0;
    logic [31:0] image_address = '0;
    logic [31:0] image_stride = '0;
    logic [15:0] clip_width = '0;
    logic [15:0] clip_height = '0;
    logic [1:0]  pixel_size_log2 = '0;
    logic [7:0]  fifo_free = 8'd255;
    logic [31:0] reader_address;
    logic [31:0] reader_length;
    logic        reader_resetn;
    logic        reader_done = 1'b0;
    logic        reader_error = 1'b0;
    logic        busy;
    logic        frame_done;
    logic [31:0] state_word;

    int n_tests = 0;
    int n_fail = 0;
    int fd_count = 0;
    int rise_cnt = 0;
    int stab_err = 0;
    logic        prev_resetn = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_len = '0;

    logic [31:0] exp_q[$];
    logic [31:0] len_q[$];

    painterengine_gpu_scanout_fetcher #(.BLOCK_WORDS(BW), .FIFO_COUNT_WIDTH(8)) dut (
        .i_wire_clock(clk),
        .i_wire_reset(rst),
        .i_wire_enable(enable),
        .i_wire_continuous(continuous),
        .i_wire_frame_start(frame_start),
        .i_wire_image_address(image_address),
        .i_wire_image_stride(image_stride),
        .i_wire_clip_width(clip_width),
        .i_wire_clip_height(clip_height),
        .i_wire_pixel_size_log2(pixel_size_log2),
        .i_wire_fifo_free_count(fifo_free),
        .o_wire_reader_address(reader_address),
        .o_wire_reader_length(reader_length),
        .o_wire_reader_resetn(reader_resetn),
        .i_wire_reader_done(reader_done),
        .i_wire_reader_error(reader_error),
        .o_wire_busy(busy),
        .o_wire_frame_done(frame_done),
        .o_wire_state(state_word)
    );

    // clock / reset-free monitors
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_done) fd_count++;
        if (reader_resetn && !prev_resetn) rise_cnt++;
        if (reader_resetn && prev_resetn &&
            (reader_address != prev_addr || reader_length != prev_len)) stab_err++;
        prev_resetn = reader_resetn;
        prev_addr   = reader_address;
        prev_len    = reader_length;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: every burst of the frame as (address, length) from geometry alone.
    task automatic build_model(input logic [31:0] base, input logic [31:0] stride,
                               input logic [15:0] w, input logic [15:0] h, input logic [1:0] sz);
        int bpp;
        int words;
        int len;
        logic [31:0] lb;
        bpp   = (sz == 2'd3) ? 4 : (1 << sz);
        words = (int'(w) * bpp + 3) / 4;
        exp_q.delete();
        len_q.delete();
        if (w == 0) return;
        for (int l = 0; l < int'(h); l++) begin
            lb = base + stride * 32'(l);
            for (int off = 0; off < words; off += BW) begin
                len = (words - off < BW) ? (words - off) : BW;
                exp_q.push_back(lb + 32'(off * 4));
                len_q.push_back(32'(len));
            end
        end
    endtask

    task automatic start_frame(input logic [31:0] base, input logic [31:0] stride,
                               input logic [15:0] w, input logic [15:0] h, input logic [1:0] sz);
        build_model(base, stride, w, h, sz);
        @(negedge clk);
        image_address   = base;
        image_stride    = stride;
        clip_width      = w;
        clip_height     = h;
        pixel_size_log2 = sz;
        frame_start     = 1'b1;
        @(negedge clk);
        frame_start     = 1'b0;
        // Mid-frame config changes must have no effect.
        image_address   = $urandom;
        image_stride    = $urandom;
        clip_width      = 16'($urandom);
        clip_height     = 16'($urandom);
        pixel_size_log2 = 2'($urandom);
    endtask

    task automatic wait_resetn(output bit ok);
        int k = 0;
        while (!reader_resetn && k < 300) begin
            @(negedge clk);
            k++;
        end
        ok = reader_resetn;
    endtask

    task automatic service(input bit mid_start, input logic [15:0] h);
        logic [31:0] ea;
        logic [31:0] el;
        bit ok;
        bit first = 1'b1;
        int k;
        while (exp_q.size() > 0) begin
            ea = exp_q.pop_front();
            el = len_q.pop_front();
            wait_resetn(ok);
            if (!ok) begin
                check("burst_start_timeout", 32'(reader_resetn), 32'd1);
                exp_q.delete();
                len_q.delete();
                return;
            end
            check("burst_addr", reader_address, ea);
            check("burst_len", reader_length, el);
            check("busy_streaming", 32'(busy), 32'd1);
            if (mid_start && first) begin
                frame_start = 1'b1;
                @(negedge clk);
                frame_start = 1'b0;
            end
            first = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            reader_done = 1'b1;
            @(negedge clk);
            reader_done = 1'b0;
            check("resetn_low_after_done", 32'(reader_resetn), 32'd0);
        end
        k = 0;
        while (!frame_done && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("frame_done_pulse", 32'(frame_done), 32'd1);
        check("state_done_on_pulse", 32'(state_word[2:0]), 32'd6);
        check("line_at_done", 32'(state_word[19:4]), 32'(h));
        @(negedge clk);
        check("frame_done_one_cycle", 32'(frame_done), 32'd0);
    endtask

    task automatic rearm();
        @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        check("rearm_wait_frame", 32'(state_word[2:0]), 32'd1);
    endtask

    initial begin
        int fd0;
        int r0;
        bit ok;
        logic [31:0] ea;
        logic [31:0] el;
        logic [15:0] rw;
        logic [15:0] rh;

        // reset
        repeat (2) @(negedge clk);
        check("reset_state", state_word, 32'd0);
        check("reset_resetn", 32'(reader_resetn), 32'd0);
        check("reset_addr", reader_address, 32'd0);
        check("reset_len", reader_length, 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_without_enable", state_word, 32'd0);
        enable = 1'b1;
        @(negedge clk);
        check("enable_to_wait_frame", state_word, 32'd1);

        // single frame, 4 B pixels, two bursts per line
        start_frame(32'h1000, 32'h200, 16'd40, 16'd2, 2'd2);
        check("model_first_burst", exp_q[0], 32'h1000);
        check("model_second_len", len_q[1], 32'd8);
        service(1'b0, 16'd2);
        repeat (2) @(negedge clk);
        check("single_frame_holds_done", 32'(state_word[2:0]), 32'd6);

        // pixel sizes
        rearm();
        start_frame(32'h4000, 32'h40, 16'd10, 16'd2, 2'd1);
        check("size2_len_model", len_q[0], 32'd5);
        service(1'b0, 16'd2);
        rearm();
        start_frame(32'h5000, 32'h10, 16'd3, 16'd1, 2'd0);
        service(1'b0, 16'd1);

        // backpressure
        rearm();
        fifo_free = 8'd20;
        start_frame(32'h2000, 32'h100, 16'd32, 16'd1, 2'd2);
        repeat (4) @(negedge clk);
        check("bp_state_wait_space", 32'(state_word[2:0]), 32'd3);
        check("bp_resetn_low", 32'(reader_resetn), 32'd0);
        fifo_free = 8'd32;
        @(negedge clk);
        check("bp_resetn_high", 32'(reader_resetn), 32'd1);
        service(1'b0, 16'd1);
        fifo_free = 8'd255;

        // error together with done on the second burst
        rearm();
        start_frame(32'h3000, 32'h100, 16'd64, 16'd1, 2'd2);
        wait_resetn(ok);
        check("err_first_burst_start", 32'(ok), 32'd1);
        reader_done = 1'b1;
        @(negedge clk);
        reader_done = 1'b0;
        wait_resetn(ok);
        check("err_second_burst_start", 32'(ok), 32'd1);
        check("err_second_addr", reader_address, 32'h3080);
        reader_done  = 1'b1;
        reader_error = 1'b1;
        @(negedge clk);
        reader_done  = 1'b0;
        reader_error = 1'b0;
        check("err_state", 32'(state_word[2:0]), 32'd7);
        check("err_flag", 32'(state_word[3]), 32'd1);
        check("err_resetn", 32'(reader_resetn), 32'd0);
        repeat (3) @(negedge clk);
        check("err_sticky", 32'(state_word[2:0]), 32'd7);
        enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        check("err_exit_idle", 32'(state_word[2:0]), 32'd0);
        check("err_flag_cleared", 32'(state_word[3]), 32'd0);
        @(negedge clk);
        check("err_rearmed", 32'(state_word[2:0]), 32'd1);
        exp_q.delete();
        len_q.delete();

        // continuous: two identical frames, stray frame_start mid-frame
        continuous = 1'b1;
        fd0 = fd_count;
        start_frame(32'h1000, 32'h200, 16'd40, 16'd2, 2'd2);
        service(1'b1, 16'd2);
        check("cont_back_to_wait", 32'(state_word[2:0]), 32'd1);
        start_frame(32'h1000, 32'h200, 16'd40, 16'd2, 2'd2);
        service(1'b0, 16'd2);
        @(negedge clk);
        check("cont_two_frame_done", 32'(fd_count - fd0), 32'd2);

        // height 0: frame_done with no reader activity
        r0 = rise_cnt;
        fd0 = fd_count;
        start_frame(32'h6000, 32'h100, 16'd16, 16'd0, 2'd2);
        service(1'b0, 16'd0);
        repeat (3) @(negedge clk);
        check("h0_no_bursts", 32'(rise_cnt - r0), 32'd0);
        check("h0_one_done", 32'(fd_count - fd0), 32'd1);

        // address wrap on the second line
        start_frame(32'hFFFFFF00, 32'h100, 16'd64, 16'd2, 2'd2);
        check("wrap_model_line1", exp_q[2], 32'h0000_0000);
        service(1'b0, 16'd2);

        // randomized frames
        for (int f = 0; f < 8; f++) begin
            ea = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            el = {$urandom_range(0, 4095), 2'b00};
            rw = 16'($urandom_range(1, 100));
            rh = 16'($urandom_range(1, 3));
            start_frame(ea, el, rw, rh, 2'($urandom_range(0, 3)));
            service(1'($urandom_range(0, 1)), rh);
        end

        @(negedge clk);
        check("addr_len_stable_while_running", 32'(stab_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
